// File: rtl/mem_bus_arbiter_pkg.sv
// Shared system definitions for the memory-bus slice: bus command encoding,
// tag-space sizing and the owner-table entry type used by the arbiter.
package sys_defs;

  localparam int XLEN     = 32;
  localparam int NUM_TAGS = 16;
  localparam int TAG_W    = 4;
  localparam int CNT_W    = $clog2(NUM_TAGS) + 1;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'b00,
    BUS_LOAD  = 2'b01,
    BUS_STORE = 2'b10
  } BUS_COMMAND;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } MEM_OWNER;

  typedef struct packed {
    logic     valid;
    MEM_OWNER owner;
  } MEM_TAG_ENTRY;

  // Tag 0 means "rejected" on responses and "nothing returning" on data.
  function automatic logic tag_is_live(input logic [TAG_W-1:0] tag);
    return tag != {TAG_W{1'b0}};
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-side signals around the arbiter.
// slave: the arbiter's view. master: the caches + memory environment.
interface mem_bus_arbiter_if;
  import sys_defs::*;

  BUS_COMMAND             icache_command;
  logic [XLEN-1:0]        icache_addr;
  BUS_COMMAND             dcache_command;
  logic [XLEN-1:0]        dcache_addr;
  logic [63:0]            dcache_data;
  logic [TAG_W-1:0]       mem2proc_response;
  logic [63:0]            mem2proc_data;
  logic [TAG_W-1:0]       mem2proc_tag;

  BUS_COMMAND             proc2mem_command;
  logic [XLEN-1:0]        proc2mem_addr;
  logic [63:0]            proc2mem_data;
  logic                   icache_grant;
  logic                   dcache_grant;
  logic [TAG_W-1:0]       icache_response;
  logic [TAG_W-1:0]       dcache_response;
  logic [TAG_W-1:0]       icache_tag;
  logic [63:0]            icache_data;
  logic [TAG_W-1:0]       dcache_tag;
  logic [63:0]            dcache_data_out;
  logic [CNT_W-1:0]       outstanding_i;
  logic [CNT_W-1:0]       outstanding_d;
  logic                   tag_error;

  modport slave (
    input  icache_command, icache_addr, dcache_command, dcache_addr, dcache_data,
           mem2proc_response, mem2proc_data, mem2proc_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data, icache_grant, dcache_grant,
           icache_response, dcache_response, icache_tag, icache_data, dcache_tag,
           dcache_data_out, outstanding_i, outstanding_d, tag_error
  );

  modport master (
    output icache_command, icache_addr, dcache_command, dcache_addr, dcache_data,
           mem2proc_response, mem2proc_data, mem2proc_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data, icache_grant, dcache_grant,
           icache_response, dcache_response, icache_tag, icache_data, dcache_tag,
           dcache_data_out, outstanding_i, outstanding_d, tag_error
  );

endinterface

// File: rtl/mem_bus_arbiter_tag_table.sv
// Owner table for memory tags: remembers which cache issued each accepted load,
// answers "who owns the returning tag" combinationally, and latches a sticky
// error on returns to unowned tags or accepts onto tags still in flight.
module mem_tag_owner_table
  import sys_defs::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              set_en,
  input  logic [TAG_W-1:0]  set_tag,
  input  MEM_OWNER          set_owner,
  input  logic [TAG_W-1:0]  ret_tag,
  output logic              ret_hit,
  output MEM_OWNER          ret_owner,
  output logic              tag_error
);

  MEM_TAG_ENTRY entries_r [NUM_TAGS];
  logic         tag_error_r;
  logic         ret_hit_s;
  logic         ret_miss_s;
  MEM_OWNER     ret_owner_s;
  logic         set_conflict_s;

  // Look up the returning tag and detect the two kinds of tag misuse.
  always_comb begin
    ret_hit_s      = 1'b0;
    ret_miss_s     = 1'b0;
    ret_owner_s    = OWN_I;
    set_conflict_s = 1'b0;
    if (tag_is_live(ret_tag)) begin
      if (entries_r[ret_tag].valid) begin
        ret_hit_s   = 1'b1;
        ret_owner_s = entries_r[ret_tag].owner;
      end else begin
        ret_miss_s  = 1'b1;
      end
    end else begin
      ret_hit_s  = 1'b0;
      ret_miss_s = 1'b0;
    end
    // A tag freed by this cycle's return may be reused immediately without error.
    if (set_en && entries_r[set_tag].valid && !(ret_hit_s && (ret_tag == set_tag))) begin
      set_conflict_s = 1'b1;
    end else begin
      set_conflict_s = 1'b0;
    end
  end

  // Table update: a set wins over a clear of the same entry (clear-then-set).
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        entries_r[i] <= '{valid: 1'b0, owner: OWN_I};
      end
    end else begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (set_en && (set_tag == TAG_W'(i))) begin
          entries_r[i] <= '{valid: 1'b1, owner: set_owner};
        end else if (ret_hit_s && (ret_tag == TAG_W'(i))) begin
          entries_r[i].valid <= 1'b0;
        end else begin
          entries_r[i] <= entries_r[i];
        end
      end
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_error_r <= 1'b0;
    end else begin
      tag_error_r <= tag_error_r | ret_miss_s | set_conflict_s;
    end
  end

  assign ret_hit   = ret_hit_s;
  assign ret_owner = ret_owner_s;
  assign tag_error = tag_error_r;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing the single memory port between I-cache and D-cache.
// D-cache normally wins; after MAX_DSTREAK consecutive D grants with I waiting,
// I is forced through. Load tags are tracked so returning data reaches its owner.
module mem_bus_arbiter
  import sys_defs::*;
#(
  parameter int MAX_DSTREAK = 4
) (
  input logic              clock,
  input logic              reset,
  mem_bus_arbiter_if.slave bus
);

  localparam int STREAK_W = $clog2(MAX_DSTREAK + 1);

  logic                i_req_s;
  logic                d_req_s;
  logic                grant_i_s;
  logic                grant_d_s;
  logic                accept_s;
  logic                load_accept_s;
  BUS_COMMAND          cmd_s;
  logic [STREAK_W-1:0] streak_r;
  logic [CNT_W-1:0]    out_i_r;
  logic [CNT_W-1:0]    out_d_r;
  logic                ret_hit_s;
  MEM_OWNER            ret_owner_s;
  logic                tag_error_s;
  logic                inc_i_s;
  logic                inc_d_s;
  logic                dec_i_s;
  logic                dec_d_s;

  assign i_req_s = (bus.icache_command != BUS_NONE);
  assign d_req_s = (bus.dcache_command != BUS_NONE);

  // Grant selection: D first unless I has waited through a full D streak.
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (d_req_s && !(i_req_s && (streak_r == STREAK_W'(MAX_DSTREAK)))) begin
      grant_d_s = 1'b1;
    end else if (i_req_s) begin
      grant_i_s = 1'b1;
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // Drive the memory port and steer the accept tag back to the granted cache.
  always_comb begin
    cmd_s                = BUS_NONE;
    bus.proc2mem_addr    = {XLEN{1'b0}};
    bus.proc2mem_data    = 64'd0;
    bus.icache_response  = {TAG_W{1'b0}};
    bus.dcache_response  = {TAG_W{1'b0}};
    case ({grant_i_s, grant_d_s})
      2'b10: begin
        cmd_s               = bus.icache_command;
        bus.proc2mem_addr   = bus.icache_addr;
        bus.icache_response = bus.mem2proc_response;
      end
      2'b01: begin
        cmd_s               = bus.dcache_command;
        bus.proc2mem_addr   = bus.dcache_addr;
        bus.proc2mem_data   = bus.dcache_data;
        bus.dcache_response = bus.mem2proc_response;
      end
      default: begin
        cmd_s = BUS_NONE;
      end
    endcase
  end

  assign bus.proc2mem_command = cmd_s;
  assign bus.icache_grant     = grant_i_s;
  assign bus.dcache_grant     = grant_d_s;

  assign accept_s      = (grant_i_s | grant_d_s) & tag_is_live(bus.mem2proc_response);
  assign load_accept_s = accept_s & (cmd_s == BUS_LOAD);

  mem_tag_owner_table u_tag_table (
    .clock     (clock),
    .reset     (reset),
    .set_en    (load_accept_s),
    .set_tag   (bus.mem2proc_response),
    .set_owner (grant_d_s ? OWN_D : OWN_I),
    .ret_tag   (bus.mem2proc_tag),
    .ret_hit   (ret_hit_s),
    .ret_owner (ret_owner_s),
    .tag_error (tag_error_s)
  );

  // Route returning data to the recorded owner; unowned returns are dropped.
  always_comb begin
    bus.icache_tag      = {TAG_W{1'b0}};
    bus.icache_data     = 64'd0;
    bus.dcache_tag      = {TAG_W{1'b0}};
    bus.dcache_data_out = 64'd0;
    if (ret_hit_s && (ret_owner_s == OWN_I)) begin
      bus.icache_tag  = bus.mem2proc_tag;
      bus.icache_data = bus.mem2proc_data;
    end else if (ret_hit_s && (ret_owner_s == OWN_D)) begin
      bus.dcache_tag      = bus.mem2proc_tag;
      bus.dcache_data_out = bus.mem2proc_data;
    end else begin
      bus.icache_tag = {TAG_W{1'b0}};
    end
  end

  // D-streak counter: counts grants (not accepts) while I is kept waiting.
  always_ff @(posedge clock) begin
    if (reset) begin
      streak_r <= {STREAK_W{1'b0}};
    end else if (grant_i_s || !i_req_s) begin
      streak_r <= {STREAK_W{1'b0}};
    end else if (grant_d_s && (streak_r != STREAK_W'(MAX_DSTREAK))) begin
      streak_r <= streak_r + STREAK_W'(1);
    end else begin
      streak_r <= streak_r;
    end
  end

  assign inc_i_s = load_accept_s & grant_i_s;
  assign inc_d_s = load_accept_s & grant_d_s;
  assign dec_i_s = ret_hit_s & (ret_owner_s == OWN_I);
  assign dec_d_s = ret_hit_s & (ret_owner_s == OWN_D);

  // Outstanding-load counter for the I-cache; simultaneous +1/-1 cancels.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_i_r <= {CNT_W{1'b0}};
    end else begin
      case ({inc_i_s, dec_i_s})
        2'b10:   out_i_r <= (out_i_r == {CNT_W{1'b1}}) ? out_i_r : out_i_r + CNT_W'(1);
        2'b01:   out_i_r <= (out_i_r == {CNT_W{1'b0}}) ? out_i_r : out_i_r - CNT_W'(1);
        default: out_i_r <= out_i_r;
      endcase
    end
  end

  // Outstanding-load counter for the D-cache; stores never count.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_d_r <= {CNT_W{1'b0}};
    end else begin
      case ({inc_d_s, dec_d_s})
        2'b10:   out_d_r <= (out_d_r == {CNT_W{1'b1}}) ? out_d_r : out_d_r + CNT_W'(1);
        2'b01:   out_d_r <= (out_d_r == {CNT_W{1'b0}}) ? out_d_r : out_d_r - CNT_W'(1);
        default: out_d_r <= out_d_r;
      endcase
    end
  end

  assign bus.outstanding_i = out_i_r;
  assign bus.outstanding_d = out_d_r;
  assign bus.tag_error     = tag_error_s;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized traffic, all compared against a tag/owner scoreboard model.
module tb_mem_bus_arbiter;
  import sys_defs::*;

  localparam int MAX_DSTREAK = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(.MAX_DSTREAK(MAX_DSTREAK)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard: which tags are in flight and who is waiting for them.
  bit   m_valid [NUM_TAGS];
  bit   m_own_d [NUM_TAGS];
  int   m_out_i, m_out_d, m_dwait;
  bit   m_err;
  logic [9:0] pat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle_inputs;
    bus.icache_command    = BUS_NONE;
    bus.icache_addr       = 32'd0;
    bus.dcache_command    = BUS_NONE;
    bus.dcache_addr       = 32'd0;
    bus.dcache_data       = 64'd0;
    bus.mem2proc_response = 4'd0;
    bus.mem2proc_data     = 64'd0;
    bus.mem2proc_tag      = 4'd0;
  endtask

  task automatic model_reset;
    for (int t = 0; t < NUM_TAGS; t++) begin
      m_valid[t] = 1'b0;
      m_own_d[t] = 1'b0;
    end
    m_out_i = 0; m_out_d = 0; m_dwait = 0; m_err = 1'b0;
  endtask

  // One clock: check every output against the model mid-cycle, then advance the model.
  task automatic tick;
    bit i_req, d_req, e_gi, e_gd, r_ok, r_d;
    logic [1:0]  e_cmd;
    logic [31:0] e_addr;
    logic [63:0] e_data;
    logic [3:0]  resp, rt;
    #2;
    resp  = bus.mem2proc_response;
    rt    = bus.mem2proc_tag;
    i_req = (bus.icache_command != BUS_NONE);
    d_req = (bus.dcache_command != BUS_NONE);
    e_gd  = d_req && !(i_req && m_dwait >= MAX_DSTREAK);
    e_gi  = i_req && !e_gd;
    e_cmd  = e_gd ? bus.dcache_command : (e_gi ? bus.icache_command : BUS_NONE);
    e_addr = e_gd ? bus.dcache_addr : (e_gi ? bus.icache_addr : 32'd0);
    e_data = e_gd ? bus.dcache_data : 64'd0;
    r_ok   = (rt != 4'd0) && m_valid[rt];
    r_d    = m_own_d[rt];
    check("proc2mem_command", bus.proc2mem_command, e_cmd);
    check("proc2mem_addr", bus.proc2mem_addr, e_addr);
    check("proc2mem_data", bus.proc2mem_data, e_data);
    check("icache_grant", bus.icache_grant, e_gi);
    check("dcache_grant", bus.dcache_grant, e_gd);
    check("icache_response", bus.icache_response, e_gi ? resp : 4'd0);
    check("dcache_response", bus.dcache_response, e_gd ? resp : 4'd0);
    check("icache_tag", bus.icache_tag, (r_ok && !r_d) ? rt : 4'd0);
    check("icache_data", bus.icache_data, (r_ok && !r_d) ? bus.mem2proc_data : 64'd0);
    check("dcache_tag", bus.dcache_tag, (r_ok && r_d) ? rt : 4'd0);
    check("dcache_data", bus.dcache_data_out, (r_ok && r_d) ? bus.mem2proc_data : 64'd0);
    check("outstanding_i", bus.outstanding_i, m_out_i);
    check("outstanding_d", bus.outstanding_d, m_out_d);
    check("tag_error", bus.tag_error, m_err);
    pat = {pat[8:0], bus.icache_grant};
    if (reset) begin
      model_reset();
    end else begin
      if (e_gi || !i_req) m_dwait = 0;
      else if (e_gd && m_dwait < MAX_DSTREAK) m_dwait++;
      if (rt != 4'd0) begin
        if (m_valid[rt]) begin
          m_valid[rt] = 1'b0;
          if (m_own_d[rt]) m_out_d--; else m_out_i--;
        end else begin
          m_err = 1'b1;
        end
      end
      if ((e_gi || e_gd) && resp != 4'd0 && e_cmd == BUS_LOAD) begin
        if (m_valid[resp]) begin
          m_err = 1'b1;
          if (m_own_d[resp]) m_out_d--; else m_out_i--;
        end
        m_valid[resp] = 1'b1;
        m_own_d[resp] = e_gd;
        if (e_gd) m_out_d++; else m_out_i++;
      end
    end
    @(posedge clock);
    #1;
  endtask

  function automatic int pick_valid();
    int s = $urandom_range(1, 15);
    for (int k = 0; k < 15; k++) begin
      int t = 1 + ((s - 1 + k) % 15);
      if (m_valid[t]) return t;
    end
    return 0;
  endfunction

  function automatic int pick_free(input int rt);
    int s = $urandom_range(1, 15);
    for (int k = 0; k < 15; k++) begin
      int t = 1 + ((s - 1 + k) % 15);
      if (!m_valid[t] || t == rt) return t;
    end
    return 0;
  endfunction

  initial begin
    int rt;
    reset = 1'b1;
    idle_inputs();
    model_reset();
    pat = 10'd0;
    @(posedge clock);
    #1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // I-only load, accepted with tag 3, later returned.
    bus.icache_command = BUS_LOAD; bus.icache_addr = 32'h100; bus.mem2proc_response = 4'd3;
    tick();
    idle_inputs();
    check("dir_out_i_after_load", bus.outstanding_i, 64'd1);
    bus.mem2proc_tag = 4'd3; bus.mem2proc_data = 64'hDEAD_BEEF_0000_1234;
    tick();
    idle_inputs();
    check("dir_out_i_after_ret", bus.outstanding_i, 64'd0);

    // D store accepted with tag 5: no entry, no outstanding change.
    bus.dcache_command = BUS_STORE; bus.dcache_addr = 32'h200;
    bus.dcache_data = 64'h1122_3344_5566_7788; bus.mem2proc_response = 4'd5;
    tick();
    idle_inputs();
    check("dir_store_out_d", bus.outstanding_d, 64'd0);

    // Same-cycle return of tag 7 (owner I) and D load reusing tag 7.
    bus.icache_command = BUS_LOAD; bus.icache_addr = 32'h300; bus.mem2proc_response = 4'd7;
    tick();
    idle_inputs();
    bus.mem2proc_tag = 4'd7; bus.mem2proc_data = 64'hAAAA_0000_0000_0007;
    bus.dcache_command = BUS_LOAD; bus.dcache_addr = 32'h400; bus.mem2proc_response = 4'd7;
    tick();
    idle_inputs();
    check("dir_reuse_out_d", bus.outstanding_d, 64'd1);
    bus.mem2proc_tag = 4'd7; bus.mem2proc_data = 64'hBBBB_0000_0000_0007;
    tick();
    idle_inputs();
    check("dir_reuse_no_err", bus.tag_error, 64'd0);

    // Both request every cycle, all rejected: starvation bound gives DDDDI DDDDI.
    tick();
    bus.icache_command = BUS_LOAD; bus.icache_addr = 32'h500;
    bus.dcache_command = BUS_LOAD; bus.dcache_addr = 32'h600;
    for (int c = 0; c < 10; c++) tick();
    check("streak_pattern", pat, 10'b0000100001);
    idle_inputs();
    tick();

    // Return on an unowned tag: dropped, sticky error.
    bus.mem2proc_tag = 4'd9; bus.mem2proc_data = 64'h9999;
    tick();
    idle_inputs();
    tick();
    tick();
    check("dir_err_sticky", bus.tag_error, 64'd1);

    // Two I loads in flight, reset for one cycle, then a stale return.
    bus.icache_command = BUS_LOAD; bus.mem2proc_response = 4'd1;
    tick();
    bus.mem2proc_response = 4'd2;
    tick();
    idle_inputs();
    check("dir_two_out_i", bus.outstanding_i, 64'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("dir_rst_out_i", bus.outstanding_i, 64'd0);
    check("dir_rst_err", bus.tag_error, 64'd0);
    bus.mem2proc_tag = 4'd1; bus.mem2proc_data = 64'h1;
    tick();
    idle_inputs();
    check("dir_stale_err", bus.tag_error, 64'd1);

    // Randomized traffic with legal tag usage from a clean reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      bus.icache_command = ($urandom_range(0, 2) != 0) ? BUS_LOAD : BUS_NONE;
      bus.icache_addr    = $urandom;
      bus.dcache_command = BUS_COMMAND'(2'($urandom_range(0, 2)));
      bus.dcache_addr    = $urandom;
      bus.dcache_data    = {$urandom, $urandom};
      bus.mem2proc_data  = {$urandom, $urandom};
      rt = ($urandom_range(0, 1) != 0) ? pick_valid() : 0;
      bus.mem2proc_tag = 4'(rt);
      bus.mem2proc_response = ($urandom_range(0, 3) != 0) ? 4'(pick_free(rt)) : 4'd0;
      tick();
    end
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
